// File: rtl/udp_pkg.sv
// udp_pkg: constants, sequencer state encoding and datapath helpers shared by
// the UDP encoder and its ones'-complement accumulator.
package udp_pkg;

    localparam logic [7:0]  UDP_PROTO     = 8'h11;
    localparam int          UDP_HDR_BYTES = 8;
    localparam logic [15:0] UDP_MAX_DATA  = 16'hFFF7;

    // Payload word counter width: ceil(UDP_MAX_DATA/4) fits in 15 bits.
    localparam int WCNT_W = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUM  = 3'd1,
        S_HDR1 = 3'd2,
        S_HDR2 = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } udp_state_e;

    // Zero the bytes of the final payload word that lie past len_data.
    // rem is len_data[1:0]; rem==0 means the last word is fully populated.
    function automatic logic [31:0] udp_mask_last(input logic [31:0] w,
                                                  input logic        last,
                                                  input logic [1:0]  rem);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        if (last) begin
            case (rem)
                2'd1:    m = 32'hFF00_0000;
                2'd2:    m = 32'hFFFF_0000;
                2'd3:    m = 32'hFFFF_FF00;
                default: m = 32'hFFFF_FFFF;
            endcase
        end
        return w & m;
    endfunction

    // 16-bit ones'-complement add with end-around carry.
    function automatic logic [15:0] oc_add16(input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// udp_csum_acc: 16-bit ones'-complement accumulator with clear, seed and
// add-both-halves-of-a-word. Clear beats seed, seed beats add.
module udp_csum_acc
    import udp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        seed_en_i,
    input  logic [15:0] seed_i,
    input  logic        add_en_i,
    input  logic [31:0] word_i,
    output logic [15:0] sum_o
);

    logic [15:0] acc_q, acc_d;

    // Next accumulator value
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (seed_en_i) begin
            acc_d = seed_i;
        end else if (add_en_i) begin
            acc_d = oc_add16(oc_add16(acc_q, word_i[31:16]), word_i[15:0]);
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_q;

endmodule

// File: rtl/udp_encoder.sv
// udp_encoder: emits a UDP datagram (header + payload) as 32-bit big-endian
// words. With CHECKSUM_EN defined a first read pass over the payload computes
// the checksum; without it the checksum field is 0000 and the header goes out
// one cycle after start.
module udp_encoder
    import udp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       src_ip,
    input  logic [31:0]       dest_ip,
    input  logic [15:0]       src_port,
    input  logic [15:0]       dest_port,
    input  logic [15:0]       len_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       data_udp,
    output logic              wr_en,
    output logic [15:0]       len_udp,
    output logic              fin,
    output logic              err
);

    localparam logic [WCNT_W-1:0] W_ONE = WCNT_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    udp_state_e        state_q;
    logic              rd_en_q, wr_en_q, fin_q, err_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [31:0]       data_q;
    logic [15:0]       len_udp_q, sport_q, dport_q;
    logic [1:0]        rem_q;
    logic [WCNT_W-1:0] nwords_q, rd_cnt_q, wcnt_q;

    logic [16:0]       len_rnd;
    logic [WCNT_W-1:0] nwords_in;
    logic [15:0]       len_udp_in;
    logic              last_word, rd_more;
    logic [31:0]       pay_word;
    logic [15:0]       csum_field;

    assign len_rnd    = {1'b0, len_data} + 17'd3;
    assign nwords_in  = len_rnd[16:2];
    assign len_udp_in = len_data + 16'(UDP_HDR_BYTES);
    assign last_word  = (wcnt_q == nwords_q - W_ONE);
    assign rd_more    = (rd_cnt_q < nwords_q);
    assign pay_word   = udp_mask_last(rd_data, last_word, rem_q);

`ifdef CHECKSUM_EN
    logic        rvld_q;
    logic [15:0] seed_val, acc_sum, csum_inv;

    // Pseudo-header + UDP header seed; length appears twice (pseudo-header and header)
    always_comb begin
        seed_val = oc_add16(src_ip[31:16], src_ip[15:0]);
        seed_val = oc_add16(seed_val, dest_ip[31:16]);
        seed_val = oc_add16(seed_val, dest_ip[15:0]);
        seed_val = oc_add16(seed_val, {8'h00, UDP_PROTO});
        seed_val = oc_add16(seed_val, len_udp_in);
        seed_val = oc_add16(seed_val, src_port);
        seed_val = oc_add16(seed_val, dest_port);
        seed_val = oc_add16(seed_val, len_udp_in);
    end

    udp_csum_acc u_acc (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clr_i    (state_q == S_DONE && !start),
        .seed_en_i(state_q == S_IDLE && start),
        .seed_i   (seed_val),
        .add_en_i (state_q == S_SUM && rvld_q),
        .word_i   (pay_word),
        .sum_o    (acc_sum)
    );

    // A computed 0000 is sent as FFFF since 0000 means "no checksum" on the wire
    assign csum_inv   = ~acc_sum;
    assign csum_field = (csum_inv == 16'h0000) ? 16'hFFFF : csum_inv;
`else
    logic unused_ip;
    assign unused_ip  = ^{src_ip, dest_ip};
    assign csum_field = 16'h0000;
`endif

    // Datagram sequencer: registered outputs, reads run one word ahead of emission
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            len_udp_q <= '0;
            fin_q     <= 1'b0;
            err_q     <= 1'b0;
            sport_q   <= '0;
            dport_q   <= '0;
            rem_q     <= '0;
            nwords_q  <= '0;
            rd_cnt_q  <= '0;
            wcnt_q    <= '0;
`ifdef CHECKSUM_EN
            rvld_q    <= 1'b0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
`ifdef CHECKSUM_EN
            rvld_q  <= rd_en_q;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_data > UDP_MAX_DATA) begin
                            err_q <= 1'b1;
                        end else begin
                            sport_q   <= src_port;
                            dport_q   <= dest_port;
                            rem_q     <= len_data[1:0];
                            nwords_q  <= nwords_in;
                            len_udp_q <= len_udp_in;
                            rd_addr_q <= '0;
                            wcnt_q    <= '0;
`ifdef CHECKSUM_EN
                            if (nwords_in != '0) begin
                                state_q  <= S_SUM;
                                rd_en_q  <= 1'b1;
                                rd_cnt_q <= W_ONE;
                            end else begin
                                state_q  <= S_HDR1;
                                wr_en_q  <= 1'b1;
                                data_q   <= {src_port, dest_port};
                                rd_cnt_q <= '0;
                            end
`else
                            state_q  <= S_HDR1;
                            wr_en_q  <= 1'b1;
                            data_q   <= {src_port, dest_port};
                            rd_en_q  <= (nwords_in != '0);
                            rd_cnt_q <= (nwords_in != '0) ? W_ONE : '0;
`endif
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_SUM: begin
                    if (rd_more) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + A_ONE;
                        rd_cnt_q  <= rd_cnt_q + W_ONE;
                    end
                    if (rvld_q) begin
                        wcnt_q <= wcnt_q + W_ONE;
                        // Last word lands in the accumulator this edge; restart reads for emission
                        if (last_word) begin
                            state_q   <= S_HDR1;
                            wr_en_q   <= 1'b1;
                            data_q    <= {sport_q, dport_q};
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                            rd_cnt_q  <= W_ONE;
                            wcnt_q    <= '0;
                        end
                    end
                end
`endif
                S_HDR1: begin
                    state_q <= S_HDR2;
                    wr_en_q <= 1'b1;
                    data_q  <= {len_udp_q, csum_field};
                    if (rd_more) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + A_ONE;
                        rd_cnt_q  <= rd_cnt_q + W_ONE;
                    end
                end
                S_HDR2, S_SEND: begin
                    if (wcnt_q == nwords_q) begin
                        state_q <= S_DONE;
                        fin_q   <= 1'b1;
                    end else begin
                        state_q <= S_SEND;
                        wr_en_q <= 1'b1;
                        data_q  <= pay_word;
                        wcnt_q  <= wcnt_q + W_ONE;
                        if (rd_more) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_addr_q + A_ONE;
                            rd_cnt_q  <= rd_cnt_q + W_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q   <= S_IDLE;
                        fin_q     <= 1'b0;
                        len_udp_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign data_udp = data_q;
    assign wr_en    = wr_en_q;
    assign len_udp  = len_udp_q;
    assign fin      = fin_q;
    assign err      = err_q;

endmodule
